// File: rtl/sniffer_input_fifo_if.sv
// ---------------------------------------------------------------------------
// sniffer_input_fifo_if
// Handshake bundle around the sniffer ingress FIFO.
//   in_*   : Avalon-ST receive stream from the Ethernet MAC (in_ready is the
//            FIFO's backpressure back to the MAC).
//   out_*  : show-ahead head-of-FIFO word towards the sniffer controller;
//            out_ready is the controller's pop request.
// Modports:
//   slave  : the FIFO side (consumes in_*, produces out_*).
//   master : the surrounding environment (MAC + controller).
// ---------------------------------------------------------------------------
interface sniffer_input_fifo_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_sop;
    logic                  in_eop;
    logic [5:0]            in_error;
    logic [1:0]            in_empty;
    logic                  in_ready;

    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_sop;
    logic                  out_eop;
    logic [5:0]            out_error;
    logic [1:0]            out_empty;

    modport slave (
        input  in_data, in_valid, in_sop, in_eop, in_error, in_empty,
        output in_ready,
        input  out_ready,
        output out_data, out_valid, out_sop, out_eop, out_error, out_empty
    );

    modport master (
        output in_data, in_valid, in_sop, in_eop, in_error, in_empty,
        input  in_ready,
        output out_ready,
        input  out_data, out_valid, out_sop, out_eop, out_error, out_empty
    );
endinterface

// File: rtl/sniffer_input_fifo.sv
// ---------------------------------------------------------------------------
// sniffer_input_fifo
// Ingress buffer between the MAC receive stream and the sniffer controller.
// Stores words with their sop/eop/error/empty sideband in a circular buffer,
// presents the head word show-ahead, and drops words that arrive outside a
// packet while counting framing faults.
// Ports:
//   clk         : system clock, rising edge
//   n_rst       : synchronous active-low reset
//   bus         : handshake bundle (slave side), see sniffer_input_fifo_if
//   flush       : synchronous flush of stored words and framing state
//   count       : words currently stored, 0..DEPTH
//   stray_count : words discarded outside a packet (saturating)
//   trunc_count : sop seen while already inside a packet (saturating)
// ---------------------------------------------------------------------------
module sniffer_input_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    sniffer_input_fifo_if.slave   bus,
    input  logic                  flush,
    output logic [ADDR_WIDTH:0]   count,
    output logic [15:0]           stray_count,
    output logic [15:0]           trunc_count
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int EW    = DATA_WIDTH + 10;   // data, sop, eop, error[6], empty[2]
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

    typedef enum logic {OUT_PKT = 1'b0, IN_PKT = 1'b1} state_t;

    logic [EW-1:0]         mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [EW-1:0]         head_q, head_d;
    logic [15:0]           stray_q, stray_d;
    logic [15:0]           trunc_q, trunc_d;
    state_t                state_q, state_d;

    logic                  accept, pop, write_en, stray_inc, trunc_inc;
    logic [EW-1:0]         wr_word;

    assign bus.in_ready  = (count_q != DEPTH_C);
    assign bus.out_valid = (count_q != '0);

    // Flush swallows the word presented in its cycle, so it gates both sides.
    assign accept  = bus.in_valid & bus.in_ready & ~flush;
    assign pop     = bus.out_valid & bus.out_ready & ~flush;
    assign wr_word = {bus.in_data, bus.in_sop, bus.in_eop, bus.in_error, bus.in_empty};

    // ---------------- framing FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!n_rst) state_q <= OUT_PKT;
        else        state_q <= state_d;
    end

    // ---------------- framing FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = OUT_PKT;
        end else if (accept) begin
            case (state_q)
                OUT_PKT: if (bus.in_sop && !bus.in_eop) state_d = IN_PKT;
                IN_PKT:  if (bus.in_eop)                state_d = OUT_PKT;
                default: state_d = OUT_PKT;
            endcase
        end
    end

    // ---------------- framing FSM: outputs ----------------
    always_comb begin
        write_en  = 1'b0;
        stray_inc = 1'b0;
        trunc_inc = 1'b0;
        if (accept) begin
            case (state_q)
                OUT_PKT: begin
                    write_en  = bus.in_sop;
                    stray_inc = ~bus.in_sop;
                end
                IN_PKT: begin
                    write_en  = 1'b1;
                    trunc_inc = bus.in_sop;
                end
                default: ;
            endcase
        end
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        stray_d  = stray_q;
        trunc_d  = trunc_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (write_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)      rd_ptr_d = rd_ptr_q + 1'b1;
            case ({write_en, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        if (stray_inc && stray_q != 16'hFFFF) stray_d = stray_q + 16'd1;
        if (trunc_inc && trunc_q != 16'hFFFF) trunc_d = trunc_q + 16'd1;

        // Registered show-ahead read: fetch the word the read pointer will
        // point at next cycle. If that slot is being written right now the
        // array still holds the old value, so forward the incoming word.
        if (write_en && (wr_ptr_q == rd_ptr_d)) head_d = wr_word;
        else                                    head_d = mem[rd_ptr_d];
    end

    // Storage array has no reset; stale contents are never exposed because
    // out_valid follows count.
    always_ff @(posedge clk) begin
        if (write_en) mem[wr_ptr_q] <= wr_word;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            stray_q  <= '0;
            trunc_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            stray_q  <= stray_d;
            trunc_q  <= trunc_d;
        end
    end

    assign bus.out_data  = head_q[EW-1 -: DATA_WIDTH];
    assign bus.out_sop   = head_q[9];
    assign bus.out_eop   = head_q[8];
    assign bus.out_error = head_q[7:2];
    assign bus.out_empty = head_q[1:0];

    assign count       = count_q;
    assign stray_count = stray_q;
    assign trunc_count = trunc_q;
endmodule

// File: tb/tb_sniffer_input_fifo.sv
// ---------------------------------------------------------------------------
// tb_sniffer_input_fifo
// Self-checking bench for sniffer_input_fifo: a table of directed vectors,
// hand-written multi-cycle sequences, and randomized traffic, all checked
// against a queue-based reference model of the buffering and framing rules.
// ---------------------------------------------------------------------------
module tb_sniffer_input_fifo;
    logic        clk = 1'b0;
    logic        n_rst;
    logic        flush;
    logic [4:0]  count;
    logic [15:0] stray_count, trunc_count;

    sniffer_input_fifo_if #(.DATA_WIDTH(32)) bus ();

    sniffer_input_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .bus         (bus),
        .flush       (flush),
        .count       (count),
        .stray_count (stray_count),
        .trunc_count (trunc_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] d;
        logic        sop;
        logic        eop;
        logic [5:0]  er;
        logic [1:0]  em;
    } ent_t;

    ent_t mq[$];
    bit   m_in_pkt;
    int   m_stray, m_trunc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Applied right after the edge, using the inputs held across it and the
    // model state as it was before the edge.
    task automatic model_update(input logic v, input logic sop, input logic eop,
                                input logic [31:0] d, input logic [5:0] er,
                                input logic [1:0] em, input logic ordy,
                                input logic fl, input logic rst);
        bit do_pop, do_acc;
        ent_t e;
        if (rst) begin
            mq.delete(); m_in_pkt = 0; m_stray = 0; m_trunc = 0;
            return;
        end
        if (fl) begin
            mq.delete(); m_in_pkt = 0;
            return;
        end
        do_pop = (mq.size() != 0) && ordy;
        do_acc = v && (mq.size() != 16);
        if (do_pop) void'(mq.pop_front());
        if (do_acc) begin
            if (!m_in_pkt && !sop) begin
                if (m_stray < 65535) m_stray++;
            end else begin
                if (m_in_pkt && sop && m_trunc < 65535) m_trunc++;
                e.d = d; e.sop = sop; e.eop = eop; e.er = er; e.em = em;
                mq.push_back(e);
                m_in_pkt = !eop;
            end
        end
    endtask

    task automatic check_model();
        chk("count", 32'(count), 32'(mq.size()));
        chk("in_ready", 32'(bus.in_ready), 32'(mq.size() != 16));
        chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("out_data", bus.out_data, mq[0].d);
            chk("out_sop", 32'(bus.out_sop), 32'(mq[0].sop));
            chk("out_eop", 32'(bus.out_eop), 32'(mq[0].eop));
            chk("out_error", 32'(bus.out_error), 32'(mq[0].er));
            chk("out_empty", 32'(bus.out_empty), 32'(mq[0].em));
        end
        chk("stray_count", 32'(stray_count), 32'(m_stray));
        chk("trunc_count", 32'(trunc_count), 32'(m_trunc));
    endtask

    // One clock: drive inputs, advance across the edge, update model, check.
    task automatic step(input logic v, input logic sop, input logic eop,
                        input logic [31:0] d, input logic [5:0] er,
                        input logic [1:0] em, input logic ordy,
                        input logic fl, input logic rst);
        bus.in_valid  = v;
        bus.in_sop    = sop;
        bus.in_eop    = eop;
        bus.in_data   = d;
        bus.in_error  = er;
        bus.in_empty  = em;
        bus.out_ready = ordy;
        flush         = fl;
        n_rst         = ~rst;
        @(posedge clk);
        model_update(v, sop, eop, d, er, em, ordy, fl, rst);
        @(negedge clk);
        check_model();
        $display("cyc t=%0t v=%0b sop=%0b eop=%0b d=%08h ordy=%0b fl=%0b rst=%0b -> count=%0d ov=%0b od=%08h stray=%0d trunc=%0d",
                 $time, v, sop, eop, d, ordy, fl, rst, count, bus.out_valid, bus.out_data,
                 stray_count, trunc_count);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 1'b0, 1'b0, 32'h0, 6'h0, 2'h0, ordy, 1'b0, 1'b0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        v, sop, eop;
        logic [31:0] d;
        logic [1:0]  em;
        logic        ordy;
        int          e_count;
        logic        e_valid;
        logic [31:0] e_data;
        logic        e_sop, e_eop;
        logic [1:0]  e_em;
        int          e_stray, e_trunc;
    } vec_t;

    vec_t tbl[16];

    initial begin
        // 3-word packet with out_ready=1, then strays, then single-word packet,
        // then a truncated packet followed by a new sop while not popping.
        tbl[0]  = '{1,1,0,32'hA0,2'd0,1, 1,1,32'hA0,1,0,2'd0, 0,0};
        tbl[1]  = '{1,0,0,32'hA1,2'd0,1, 1,1,32'hA1,0,0,2'd0, 0,0};
        tbl[2]  = '{1,0,1,32'hA2,2'd2,1, 1,1,32'hA2,0,1,2'd2, 0,0};
        tbl[3]  = '{0,0,0,32'h00,2'd0,1, 0,0,32'h00,0,0,2'd0, 0,0};
        tbl[4]  = '{1,0,0,32'h5A0,2'd0,1, 0,0,32'h00,0,0,2'd0, 1,0};
        tbl[5]  = '{1,0,1,32'h5A1,2'd0,1, 0,0,32'h00,0,0,2'd0, 2,0};
        tbl[6]  = '{1,1,1,32'hB0,2'd1,1, 1,1,32'hB0,1,1,2'd1, 2,0};
        tbl[7]  = '{0,0,0,32'h00,2'd0,1, 0,0,32'h00,0,0,2'd0, 2,0};
        tbl[8]  = '{1,1,0,32'hC0,2'd0,0, 1,1,32'hC0,1,0,2'd0, 2,0};
        tbl[9]  = '{1,0,0,32'hC1,2'd0,0, 2,1,32'hC0,1,0,2'd0, 2,0};
        tbl[10] = '{1,0,0,32'hC2,2'd0,0, 3,1,32'hC0,1,0,2'd0, 2,0};
        tbl[11] = '{1,1,1,32'hD0,2'd3,0, 4,1,32'hC0,1,0,2'd0, 2,1};
        tbl[12] = '{0,0,0,32'h00,2'd0,1, 3,1,32'hC1,0,0,2'd0, 2,1};
        tbl[13] = '{0,0,0,32'h00,2'd0,1, 2,1,32'hC2,0,0,2'd0, 2,1};
        tbl[14] = '{0,0,0,32'h00,2'd0,1, 1,1,32'hD0,1,1,2'd3, 2,1};
        tbl[15] = '{0,0,0,32'h00,2'd0,1, 0,0,32'h00,0,0,2'd0, 2,1};

        // ---- reset ----
        step(1'b0, 1'b0, 1'b0, 32'h0, 6'h0, 2'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 6'h0, 2'h0, 1'b0, 1'b0, 1'b1);
        chk("reset_out_data", bus.out_data, 32'h0);
        chk("reset_out_sop", 32'(bus.out_sop), 32'h0);
        chk("reset_in_ready", 32'(bus.in_ready), 32'h1);

        // ---- table-driven vectors ----
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].v, tbl[i].sop, tbl[i].eop, tbl[i].d, 6'h0, tbl[i].em,
                 tbl[i].ordy, 1'b0, 1'b0);
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_count));
            chk($sformatf("tbl%0d_valid", i), 32'(bus.out_valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_stray", i), 32'(stray_count), 32'(tbl[i].e_stray));
            chk($sformatf("tbl%0d_trunc", i), 32'(trunc_count), 32'(tbl[i].e_trunc));
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_data", i), bus.out_data, tbl[i].e_data);
                chk($sformatf("tbl%0d_sop", i), 32'(bus.out_sop), 32'(tbl[i].e_sop));
                chk($sformatf("tbl%0d_eop", i), 32'(bus.out_eop), 32'(tbl[i].e_eop));
                chk($sformatf("tbl%0d_empty", i), 32'(bus.out_empty), 32'(tbl[i].e_em));
            end
        end

        // ---- fill to full, 17th refused, single pop, refill across wrap ----
        for (int i = 0; i < 16; i++)
            step(1'b1, (i == 0), 1'b0, 32'h1000 + i, 6'(i), 2'h0, 1'b0, 1'b0, 1'b0);
        chk("full_count", 32'(count), 32'd16);
        chk("full_in_ready", 32'(bus.in_ready), 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'hDEAD, 6'h0, 2'h0, 1'b0, 1'b0, 1'b0);
        chk("full_17th_refused", 32'(count), 32'd16);
        step(1'b1, 1'b0, 1'b0, 32'hDEAD, 6'h0, 2'h0, 1'b1, 1'b0, 1'b0);
        chk("one_pop_count", 32'(count), 32'd15);
        chk("one_pop_in_ready", 32'(bus.in_ready), 32'h1);
        for (int i = 0; i < 15; i++) idle(1'b1);
        chk("drained", 32'(count), 32'd0);
        for (int i = 0; i < 16; i++)
            step(1'b1, 1'b0, (i == 15), 32'h2000 + i, 6'h0, 2'(i), 1'b0, 1'b0, 1'b0);
        chk("refill_count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) idle(1'b1);

        // ---- simultaneous push/pop at count=5 ----
        for (int i = 0; i < 5; i++)
            step(1'b1, (i == 0), 1'b0, 32'h3000 + i, 6'h0, 2'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h3100 + i, 6'h0, 2'h0, 1'b1, 1'b0, 1'b0);
            chk($sformatf("pushpop%0d_count", i), 32'(count), 32'd5);
        end
        for (int i = 0; i < 5; i++) idle(1'b1);

        // ---- flush with 7 stored words and a word presented ----
        for (int i = 0; i < 7; i++)
            step(1'b1, 1'b0, 1'b0, 32'h4000 + i, 6'h0, 2'h0, 1'b0, 1'b0, 1'b0);
        chk("preflush_count", 32'(count), 32'd7);
        step(1'b1, 1'b0, 1'b0, 32'h4FFF, 6'h0, 2'h0, 1'b1, 1'b1, 1'b0);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_out_valid", 32'(bus.out_valid), 32'h0);
        chk("flush_stray_kept", 32'(stray_count), 32'd2);
        chk("flush_trunc_kept", 32'(trunc_count), 32'd1);
        // After flush the FSM is outside a packet: a non-sop word is stray.
        step(1'b1, 1'b0, 1'b0, 32'h4ABC, 6'h0, 2'h0, 1'b0, 1'b0, 1'b0);
        chk("postflush_stray", 32'(stray_count), 32'd3);
        step(1'b1, 1'b1, 1'b0, 32'h5000, 6'h0, 2'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h5001, 6'h0, 2'h0, 1'b0, 1'b0, 1'b0);
        // Reset mid-packet.
        step(1'b1, 1'b0, 1'b0, 32'h5002, 6'h0, 2'h0, 1'b0, 1'b0, 1'b1);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'h1);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("midrst_out_data", bus.out_data, 32'h0);
        chk("midrst_out_eop", 32'(bus.out_eop), 32'h0);
        chk("midrst_stray", 32'(stray_count), 32'd0);
        chk("midrst_trunc", 32'(trunc_count), 32'd0);

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 7,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom(),
                 6'($urandom_range(0, 63)),
                 2'($urandom_range(0, 3)),
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 49) == 0,
                 $urandom_range(0, 199) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sniffer_input_fifo.md
Name: sniffer_input_fifo

Overview:
- Ingress buffer between the Ethernet MAC's Avalon-ST receive interface and the sniffer controller/comparator stage.
- Stores receive words with their sop/eop/error/empty sideband and backpressures the MAC when full.
- Presents a show-ahead word stream to the controller, which pops using its ready output.
- A framing checker discards stray words that arrive outside a packet and counts framing faults for Avalon-slave readout.

Parameters:
DATA_WIDTH, 32, width of the MAC data word
ADDR_WIDTH, 4, log2 of FIFO depth (DEPTH = 2**ADDR_WIDTH = 16 words)

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  reset, synchronous, active-low
in_data  in  DATA_WIDTH  MAC receive data
in_valid  in  1  MAC word valid
in_sop  in  1  MAC start of packet
in_eop  in  1  MAC end of packet
in_error  in  6  MAC error flags
in_empty  in  2  MAC empty-byte count on eop word
in_ready  out  1  FIFO can accept a word
out_ready  in  1  pop request from controller (its ready)
out_data  out  DATA_WIDTH  head word data
out_valid  out  1  head word valid (FIFO not empty)
out_sop  out  1  head word sop
out_eop  out  1  head word eop
out_error  out  6  head word error
out_empty  out  2  head word empty; also drives controller empty input
flush  in  1  synchronous flush of contents and framing state
count  out  ADDR_WIDTH+1  words currently stored, 0..DEPTH
stray_count  out  16  words discarded outside a packet, saturating
trunc_count  out  16  sop seen while already inside a packet, saturating

Behaviour:
- Clock/reset: single clock clk; reset n_rst is synchronous and active-low, sampled only on rising clk.
- Reset (n_rst=0 at an edge): pointers=0, count=0, out_valid=0, out_sop/eop=0, out_data/error/empty=0, in_ready=1 from the following cycle, stray_count=0, trunc_count=0, framing FSM=OUT_PKT.
- Reset asserted mid-packet discards all stored words; the stored data is not required to be cleared.
- Storage: entry = {data, sop, eop, error[5:0], empty[1:0]}; circular buffer with ADDR_WIDTH-bit read/write pointers wrapping DEPTH-1 -> 0.
- Readiness: in_ready = (count != DEPTH), combinational from registered count.
- Accepted input: a word is accepted when in_valid & in_ready.
- Pop: occurs when out_valid & out_ready.
- Output timing: out_valid = (count != 0); out_* reflect the word at the read pointer (show-ahead). A word written at edge N is visible on out_* after edge N, i.e. in the cycle following acceptance (1-cycle latency).
- Count update: count += push - pop.
  - Push and pop in the same cycle leave count unchanged.
  - When empty, a push with out_ready=1 does not pop that word in the same cycle.
  - When full, in_ready=0, so no push occurs; a pop in that cycle frees a slot and in_ready=1 next cycle.
- Framing FSM, evaluated only on accepted words:
  - OUT_PKT, sop=1: write the word; stay in OUT_PKT if eop=1, else go to IN_PKT.
  - OUT_PKT, sop=0: do not write; stray_count+1. The word is still consumed (in_ready unchanged).
  - IN_PKT, sop=1: write the word; trunc_count+1; stay in IN_PKT, or go to OUT_PKT if eop=1.
  - IN_PKT, sop=0: write the word; go to OUT_PKT if eop=1.
  - Words with a nonzero error field are written unchanged; the controller handles them.
- Counters: 16-bit, saturate at 0xFFFF with no wrap; cleared only by reset, not by flush.
- Flush (flush=1 at an edge, n_rst=1):
  - Pointers=0, count=0, FSM=OUT_PKT.
  - Flush overrides any simultaneous push or pop; the word presented that cycle is neither written nor counted.
  - out_valid=0 from the next cycle.
- Reset has priority over flush.

Test Plan:
1. Reset, then a 3-word packet (sop on word0, eop on word2, empty=2), out_ready=1 -> out_valid high the cycle after each accept; out sequence sop,-,eop with out_empty=2 on the last word; count returns to 0; both counters stay 0.
2. out_ready=0, push 16 words of one packet -> count=16 and in_ready=0 after the 16th accept; a 17th in_valid word is not taken. Raise out_ready for 1 cycle -> count=15, in_ready=1 next cycle; pointers wrap correctly over a second fill of 16 words.
3. Simultaneous push and pop at count=5 for 4 cycles -> count stays 5; output order matches input order.
4. Two words with sop=0 while in OUT_PKT -> neither appears at the output; stray_count=2. Then a single-word packet (sop=eop=1) -> passes through; FSM stays OUT_PKT.
5. Packet A sop plus 2 words with no eop, then packet B sop -> trunc_count=1; all 4 words appear at the output in order.
6. FIFO holding 7 words, assert flush with in_valid=1 -> next cycle count=0, out_valid=0, the flushed-cycle word is absent, counters retained. Then hold n_rst=0 for 1 edge mid-packet -> everything at reset values and in_ready=1.
